dm_cache_controller: RTL and testbench

Sequential responder on the CPU memory-request interface driven by the main decoder (MemReadCpu / MemWrite). It implements the control path of a direct-mapped, write-through, no-write-allocate data cache. It owns the tag/valid store, stalls the single-cycle core on misses and writes, and sequences word-by-word refills and write-throughs to main memory over a req/ready handshake. The data array and data muxing are external; this block drives only their enables and selects.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/dm_cache_controller_if.sv | 30 +++
 rtl/tag_valid_store.sv | 38 +++
 rtl/dm_cache_controller.sv | 117 +++++++++++
 tb/tb_dm_cache_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped cache controller.
package cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int NUM_BLK  = 1 << INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REFILL     = 2'd1,
        ST_WRITE_THRU = 2'd2
    } state_e;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// CPU request, data-array control and main-memory handshake signals of the cache controller.
interface dm_cache_controller_if;
    import cache_pkg::*;

    logic                        MemReadCpu;
    logic                        MemWriteCpu;
    logic [ADDR_W-1:0]           cpu_addr;
    logic                        stall;
    logic                        hit;
    logic                        cache_we;
    logic                        cache_src;
    logic [INDEX_W+OFFSET_W-1:0] cache_addr;
    logic                        mem_rd_req;
    logic                        mem_wr_req;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_ready;

    modport slave (
        input  MemReadCpu, MemWriteCpu, cpu_addr, mem_ready,
        output stall, hit, cache_we, cache_src, cache_addr,
               mem_rd_req, mem_wr_req, mem_addr
    );

    modport master (
        output MemReadCpu, MemWriteCpu, cpu_addr, mem_ready,
        input  stall, hit, cache_we, cache_src, cache_addr,
               mem_rd_req, mem_wr_req, mem_addr
    );

endinterface

// File: rtl/tag_valid_store.sv
// Tag/valid register array with one write port and a combinational lookup compare.
module tag_valid_store
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    input  logic               wr_en,
    output logic               hit
);

    logic [NUM_BLK-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [NUM_BLK];
    logic [TAG_W-1:0]   tag_d [NUM_BLK];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (wr_en) begin
            valid_d[index] = 1'b1;
            tag_d[index]   = tag;
        end
    end

    // Only the valid bits need clearing; a stale tag is harmless behind valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q <= tag_d;
    end

    assign hit = valid_q[index] && (tag_q[index] == tag);

endmodule

// File: rtl/dm_cache_controller.sv
// Control path of a direct-mapped, write-through, no-write-allocate data cache.
//   state         | meaning
//   ST_IDLE       | lookup; read hits complete with no stall
//   ST_REFILL     | fetch the 4 words of the missed block, cnt selects the word
//   ST_WRITE_THRU | forward the store to memory, update the array on a hit
module dm_cache_controller
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    dm_cache_controller_if.slave  bus
);

    state_e                state_q, state_d;
    logic [OFFSET_W-1:0]   cnt_q, cnt_d;
    logic                  tv_we;
    logic                  lookup_hit;
    logic [TAG_W-1:0]      a_tag;
    logic [INDEX_W-1:0]    a_index;
    logic [OFFSET_W-1:0]   a_offset;

    assign a_tag    = get_tag(bus.cpu_addr);
    assign a_index  = get_index(bus.cpu_addr);
    assign a_offset = get_offset(bus.cpu_addr);

    tag_valid_store u_tv (
        .clk   (clk),
        .rst   (rst),
        .index (a_index),
        .tag   (a_tag),
        .wr_en (tv_we),
        .hit   (lookup_hit)
    );

    assign bus.hit = lookup_hit;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tv_we          = 1'b0;
        bus.stall      = 1'b0;
        bus.cache_we   = 1'b0;
        bus.cache_src  = 1'b0;
        bus.cache_addr = '0;
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        bus.mem_addr   = '0;

        unique case (state_q)
            ST_IDLE: begin
                // A simultaneous read and write is illegal; the write wins.
                if (bus.MemWriteCpu) begin
                    bus.stall = 1'b1;
                    state_d   = ST_WRITE_THRU;
                end else if (bus.MemReadCpu && !lookup_hit) begin
                    bus.stall = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REFILL;
                end
            end

            ST_REFILL: begin
                bus.stall      = 1'b1;
                bus.mem_rd_req = 1'b1;
                bus.mem_addr   = {a_tag, a_index, cnt_q};
                if (bus.mem_ready) begin
                    bus.cache_we   = 1'b1;
                    bus.cache_src  = 1'b1;
                    bus.cache_addr = {a_index, cnt_q};
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        tv_we   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WRITE_THRU: begin
                bus.stall      = 1'b1;
                bus.mem_wr_req = 1'b1;
                bus.mem_addr   = bus.cpu_addr;
                if (bus.mem_ready) begin
                    bus.stall = 1'b0;
                    state_d   = ST_IDLE;
                    // No allocation on a write miss: only a resident block is updated.
                    if (lookup_hit) begin
                        bus.cache_we   = 1'b1;
                        bus.cache_src  = 1'b0;
                        bus.cache_addr = {a_index, a_offset};
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Reset can arrive mid-transaction; silence every request in that cycle.
        if (rst) begin
            tv_we          = 1'b0;
            bus.stall      = 1'b0;
            bus.cache_we   = 1'b0;
            bus.mem_rd_req = 1'b0;
            bus.mem_wr_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Self-checking bench: bench acts as CPU and memory, checked against a tag/valid array model.
module tb_dm_cache_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic        m_valid [32];
    logic [2:0]  m_tag   [32];

    dm_cache_controller_if bus ();

    dm_cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    endtask

    // Read access: lookup cycle, then a full 4-word refill when the model says miss.
    task automatic run_read(input logic [9:0] addr, input int w, output int n_stall, output int n_req);
        logic [4:0] idx;
        logic [2:0] tg;
        logic       eh;
        logic [4:0] obs, exp;
        logic [1:0] kk;
        idx = addr[6:2];
        tg  = addr[9:7];
        eh  = m_valid[idx] && (m_tag[idx] == tg);
        n_stall = 0;
        n_req   = 0;
        @(posedge clk); #1;
        bus.MemReadCpu  = 1'b1;
        bus.MemWriteCpu = 1'b0;
        bus.cpu_addr    = addr;
        bus.mem_ready   = 1'($urandom_range(0, 1));
        #2;
        obs = {bus.stall, bus.hit, bus.mem_rd_req, bus.mem_wr_req, bus.cache_we};
        exp = {!eh, eh, 3'b000};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rd_lookup addr=%h {stall,hit,rd,wr,we} act=%b exp=%b", addr, obs, exp);
        end
        n_stall += int'(bus.stall);
        if (!eh) begin
            for (int k = 0; k < 4; k++) begin
                kk = k[1:0];
                for (int c = 0; c <= w; c++) begin
                    @(posedge clk); #1;
                    bus.mem_ready = (c == w);
                    #2;
                    obs = {bus.stall, bus.hit, bus.mem_rd_req, bus.mem_wr_req, bus.cache_we};
                    exp = {4'b1010, (c == w)};
                    n_checks++;
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL refill_ctl addr=%h word=%0d act=%b exp=%b", addr, k, obs, exp);
                    end
                    n_checks++;
                    if (bus.mem_addr !== {addr[9:2], kk}) begin
                        n_fail++;
                        $display("FAIL refill_addr act=%h exp=%h", bus.mem_addr, {addr[9:2], kk});
                    end
                    if (c == w) begin
                        n_checks++;
                        if ({bus.cache_src, bus.cache_addr} !== {1'b1, addr[6:2], kk}) begin
                            n_fail++;
                            $display("FAIL refill_wr {src,caddr} act=%h exp=%h",
                                     {bus.cache_src, bus.cache_addr}, {1'b1, addr[6:2], kk});
                        end
                    end
                    n_stall += int'(bus.stall);
                    n_req   += int'(bus.mem_rd_req);
                end
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            @(posedge clk); #1;
            bus.mem_ready = 1'($urandom_range(0, 1));
            #2;
            obs = {bus.stall, bus.hit, bus.mem_rd_req, bus.mem_wr_req, bus.cache_we};
            n_checks++;
            if (obs !== 5'b01000) begin
                n_fail++;
                $display("FAIL refill_done addr=%h act=%b exp=01000", addr, obs);
            end
            n_stall += int'(bus.stall);
        end
        bus.MemReadCpu = 1'b0;
        bus.mem_ready  = 1'b0;
    endtask

    // Write access (optionally with the read request also high): write-through, no allocate.
    task automatic run_write(input logic [9:0] addr, input int w, input logic both, output int n_req);
        logic       eh;
        logic [4:0] obs, exp;
        eh    = m_valid[addr[6:2]] && (m_tag[addr[6:2]] == addr[9:7]);
        n_req = 0;
        @(posedge clk); #1;
        bus.MemReadCpu  = both;
        bus.MemWriteCpu = 1'b1;
        bus.cpu_addr    = addr;
        bus.mem_ready   = 1'($urandom_range(0, 1));
        #2;
        obs = {bus.stall, bus.hit, bus.mem_rd_req, bus.mem_wr_req, bus.cache_we};
        exp = {1'b1, eh, 3'b000};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL wr_lookup addr=%h act=%b exp=%b", addr, obs, exp);
        end
        for (int c = 0; c <= w; c++) begin
            @(posedge clk); #1;
            bus.mem_ready = (c == w);
            #2;
            obs = {bus.stall, bus.hit, bus.mem_rd_req, bus.mem_wr_req, bus.cache_we};
            exp = {(c != w), eh, 2'b01, (c == w) && eh};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL wr_ctl addr=%h cyc=%0d act=%b exp=%b", addr, c, obs, exp);
            end
            n_checks++;
            if (bus.mem_addr !== addr) begin
                n_fail++;
                $display("FAIL wr_addr act=%h exp=%h", bus.mem_addr, addr);
            end
            if ((c == w) && eh) begin
                n_checks++;
                if ({bus.cache_src, bus.cache_addr} !== {1'b0, addr[6:0]}) begin
                    n_fail++;
                    $display("FAIL wr_update {src,caddr} act=%h exp=%h",
                             {bus.cache_src, bus.cache_addr}, {1'b0, addr[6:0]});
                end
            end
            n_req += int'(bus.mem_wr_req);
        end
        @(posedge clk); #1;
        bus.MemReadCpu  = 1'b0;
        bus.MemWriteCpu = 1'b0;
        bus.mem_ready   = 1'b0;
        #2;
        obs = {bus.stall, bus.hit, bus.mem_rd_req, bus.mem_wr_req, bus.cache_we};
        exp = {1'b0, eh, 3'b000};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL wr_done addr=%h act=%b exp=%b", addr, obs, exp);
        end
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1;
        bus.MemReadCpu  = 1'b1;
        bus.MemWriteCpu = 1'b0;
        bus.cpu_addr    = 10'h0A5;
        bus.mem_ready   = 1'b1;
        @(posedge clk); #3;
        obs = {bus.stall, bus.mem_rd_req, bus.mem_wr_req, bus.cache_we};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs {stall,rd,wr,we} act=%b exp=0000", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.MemReadCpu = 1'b0;
        bus.mem_ready  = 1'b0;
        model_clear();
        #2;
        obs = {bus.stall, bus.hit, bus.mem_rd_req, bus.mem_wr_req};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle {stall,hit,rd,wr} act=%b exp=0000", obs);
        end
    endtask

    task automatic test_refill();
        int ns, nr;
        run_read(10'h0A5, 2, ns, nr);
        n_checks++;
        if (nr !== 12) begin
            n_fail++;
            $display("FAIL refill_req_cycles act=%0d exp=12", nr);
        end
        n_checks++;
        if (ns !== 13) begin
            n_fail++;
            $display("FAIL refill_stall_cycles act=%0d exp=13", ns);
        end
    endtask

    task automatic test_read_hit();
        int ns, nr;
        run_read(10'h0A6, 1, ns, nr);
        n_checks++;
        if (ns !== 0) begin
            n_fail++;
            $display("FAIL read_hit_stall act=%0d exp=0", ns);
        end
    endtask

    task automatic test_write_hit();
        int nr;
        run_write(10'h0A7, 3, 1'b0, nr);
        n_checks++;
        if (nr !== 4) begin
            n_fail++;
            $display("FAIL write_req_cycles act=%0d exp=4", nr);
        end
    endtask

    task automatic test_write_miss();
        int ns, nr;
        run_write(10'h1E0, 1, 1'b0, nr);
        run_read(10'h1E0, 1, ns, nr);
        n_checks++;
        if (nr !== 8) begin
            n_fail++;
            $display("FAIL write_miss_no_alloc refill_req act=%0d exp=8", nr);
        end
    endtask

    task automatic test_conflict();
        int ns, nr;
        run_read(10'h2A5, 0, ns, nr);
        n_checks++;
        if (nr !== 4) begin
            n_fail++;
            $display("FAIL conflict_refill act=%0d exp=4", nr);
        end
        run_read(10'h0A5, 1, ns, nr);
        n_checks++;
        if (nr !== 8) begin
            n_fail++;
            $display("FAIL conflict_remiss act=%0d exp=8", nr);
        end
    endtask

    task automatic test_reset_mid_refill();
        int ns, nr;
        logic [2:0] obs;
        // Stay clear of a resident block so this is guaranteed to miss.
        @(posedge clk); #1;
        bus.MemReadCpu = 1'b1;
        bus.cpu_addr   = 10'h355;
        bus.mem_ready  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            bus.mem_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_rd_req, bus.mem_addr} !== {1'b1, 10'h356}) begin
            n_fail++;
            $display("FAIL midrst_cnt2 {rd,addr} act=%h exp=%h", {bus.mem_rd_req, bus.mem_addr}, {1'b1, 10'h356});
        end
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        obs = {bus.mem_rd_req, bus.mem_wr_req, bus.cache_we};
        n_checks++;
        if (obs !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_outputs {rd,wr,we} act=%b exp=000", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.MemReadCpu = 1'b0;
        bus.mem_ready  = 1'b0;
        model_clear();
        #2;
        n_checks++;
        if ({bus.stall, bus.mem_rd_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_idle {stall,rd} act=%b exp=00", {bus.stall, bus.mem_rd_req});
        end
        run_read(10'h0A5, 0, ns, nr);
        n_checks++;
        if (nr !== 4) begin
            n_fail++;
            $display("FAIL midrst_valid_cleared act=%0d exp=4", nr);
        end
        run_write(10'h0A6, 2, 1'b1, nr);
        n_checks++;
        if (nr !== 3) begin
            n_fail++;
            $display("FAIL both_high_write_path act=%0d exp=3", nr);
        end
    endtask

    task automatic test_random();
        int ns, nr, op, w;
        logic [4:0] idx_set [4];
        logic [9:0] a;
        idx_set[0] = 5'h09; idx_set[1] = 5'h0A; idx_set[2] = 5'h14; idx_set[3] = 5'h1F;
        for (int i = 0; i < 40; i++) begin
            a[9:7] = 3'($urandom_range(0, 3));
            a[6:2] = idx_set[$urandom_range(0, 3)];
            a[1:0] = 2'($urandom_range(0, 3));
            w  = $urandom_range(0, 3);
            op = $urandom_range(0, 3);
            if (op < 2) run_read(a, w, ns, nr);
            else        run_write(a, w, (op == 3), nr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.MemReadCpu  = 1'b0;
        bus.MemWriteCpu = 1'b0;
        bus.cpu_addr    = '0;
        bus.mem_ready   = 1'b0;
        model_clear();
        for (int i = 0; i < 32; i++) m_tag[i] = '0;
        test_reset();
        test_refill();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_refill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
